// File: rtl/beat_run_sequencer.sv
// Beat sequencer for the hardwired instruction controller.
// Issues one-hot W[3:1] beats, stretches or shortens each machine cycle on
// the controller's SHORT/LONG requests, and stops on STOP, single-step mode
// or a PC breakpoint. Counts completed machine cycles for the console.
// All state changes on the falling edge of T3; #CLR is asynchronous.
//
// Handshake: there is no valid/ready pair here. A start event is a rising
// level on QD as seen across two consecutive falling T3 edges; it is honoured
// only while idle, and the controller's SHORT/LONG/STOP/LIR are sampled on
// the same falling edge that leaves the current beat.
module beat_run_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              T3,
    input  logic              CLR,
    input  logic              QD,
    input  logic              STEP,
    input  logic              SHORT,
    input  logic              LONG,
    input  logic              STOP,
    input  logic              LIR,
    input  logic [ADDR_W-1:0] PC,
    input  logic              BRK_EN,
    input  logic [ADDR_W-1:0] BRK_ADDR,
    output logic [3:1]        W,
    output logic              RUN,
    output logic              BRK_HIT,
    output logic [CNT_W-1:0]  CYC_CNT,
    output logic [1:0]        DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B1   = 2'd1,
        S_B2   = 2'd2,
        S_B3   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               qd_q;
    logic               stop_pend_q, stop_pend_d;
    logic               brk_hit_q, brk_hit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:1]         w_q;
    logic               run_q;

    logic               start;
    logic               brk_match;
    logic               end_cycle;
    logic               halt;

    function automatic logic [3:1] beat_of(input state_e s);
        case (s)
            S_B1:    beat_of = 3'b001;
            S_B2:    beat_of = 3'b010;
            S_B3:    beat_of = 3'b100;
            default: beat_of = 3'b000;
        endcase
    endfunction

    // Next-state, end-of-cycle and halt decision for the beat sequence.
    always_comb begin
        start       = QD & ~qd_q;
        brk_match   = BRK_EN & LIR & (PC == BRK_ADDR);
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        brk_hit_d   = brk_hit_q;
        cnt_d       = cnt_q;
        end_cycle   = 1'b0;
        halt        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_B1;
                    brk_hit_d   = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            S_B1: begin
                // SHORT takes priority over LONG in the first beat.
                end_cycle = SHORT;
                if (!SHORT) state_d = S_B2;
            end
            S_B2: begin
                end_cycle = ~LONG;
                if (LONG) state_d = S_B3;
            end
            default: begin
                end_cycle = 1'b1;
            end
        endcase

        if (state_q != S_IDLE) begin
            if (STOP)      stop_pend_d = 1'b1;
            if (brk_match) brk_hit_d   = 1'b1;
        end

        if (end_cycle) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            // BRK_HIT is cleared at every start and any match halts at the end
            // of its own cycle, so a set flag while running means "this cycle".
            halt = stop_pend_q | STOP | STEP | brk_hit_q | brk_match;
            if (halt) begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
            end else begin
                state_d     = S_B1;
            end
        end
    end

    // State, flags, counter and registered beat outputs on falling T3.
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            state_q     <= S_IDLE;
            qd_q        <= 1'b0;
            stop_pend_q <= 1'b0;
            brk_hit_q   <= 1'b0;
            cnt_q       <= '0;
            w_q         <= 3'b000;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            qd_q        <= QD;
            stop_pend_q <= stop_pend_d;
            brk_hit_q   <= brk_hit_d;
            cnt_q       <= cnt_d;
            w_q         <= beat_of(state_d);
            run_q       <= (state_d != S_IDLE);
        end
    end

    assign W         = w_q;
    assign RUN       = run_q;
    assign BRK_HIT   = brk_hit_q;
    assign CYC_CNT   = cnt_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_beat_run_sequencer.sv
// Bench for beat_run_sequencer: directed scenarios with hand-computed
// expectations, then randomized stimulus, all checked every cycle against a
// cycle-level model that counts beats within a machine cycle.
module tb_beat_run_sequencer;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 4;

    logic              T3 = 1'b1;
    logic              CLR = 1'b0;
    logic              QD = 1'b0;
    logic              STEP = 1'b0;
    logic              SHORT = 1'b0;
    logic              LONG = 1'b0;
    logic              STOP = 1'b0;
    logic              LIR = 1'b0;
    logic [ADDR_W-1:0] PC = '0;
    logic              BRK_EN = 1'b0;
    logic [ADDR_W-1:0] BRK_ADDR = '0;
    logic [3:1]        W;
    logic              RUN;
    logic              BRK_HIT;
    logic [CNT_W-1:0]  CYC_CNT;
    logic [1:0]        DBG_STATE;

    beat_run_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .T3(T3), .CLR(CLR), .QD(QD), .STEP(STEP), .SHORT(SHORT), .LONG(LONG),
        .STOP(STOP), .LIR(LIR), .PC(PC), .BRK_EN(BRK_EN), .BRK_ADDR(BRK_ADDR),
        .W(W), .RUN(RUN), .BRK_HIT(BRK_HIT), .CYC_CNT(CYC_CNT),
        .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    initial forever #5 T3 = ~T3;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: inputs change 1ns after the rising edge, far from the sampling edge
    task automatic step();
        @(posedge T3);
        #1;
    endtask

    // behavioural model: beat number inside the machine cycle (0 = idle)
    int m_beat = 0;
    int m_cnt  = 0;
    bit m_qd   = 0;
    bit m_brk  = 0;
    bit c_stop = 0;
    bit c_match = 0;
    bit m_start;
    bit m_last;

    always @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            m_beat = 0; m_cnt = 0; m_qd = 0; m_brk = 0; c_stop = 0; c_match = 0;
        end else begin
            m_start = QD && !m_qd;
            m_qd = QD;
            if (m_beat == 0) begin
                if (m_start) begin
                    m_beat = 1;
                    m_brk = 0;
                    c_stop = 0;
                    c_match = 0;
                end
            end else begin
                if (STOP) c_stop = 1;
                if (BRK_EN && LIR && PC == BRK_ADDR) begin
                    c_match = 1;
                    m_brk = 1;
                end
                m_last = (m_beat == 1 && SHORT) || (m_beat == 2 && !LONG) || (m_beat == 3);
                if (m_last) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    m_beat = (c_stop || STEP || c_match) ? 0 : 1;
                    c_stop = 0;
                    c_match = 0;
                end else begin
                    m_beat = m_beat + 1;
                end
            end
        end
    end

    // scoreboard compare on every rising edge (outputs move on falling edges)
    always @(posedge T3) begin
        check("W", {29'b0, W}, (m_beat == 0) ? 32'd0 : (32'd1 << (m_beat - 1)));
        check("RUN", {31'b0, RUN}, {31'b0, (m_beat != 0)});
        check("BRK_HIT", {31'b0, BRK_HIT}, {31'b0, m_brk});
        check("CYC_CNT", {28'b0, CYC_CNT}, m_cnt);
    end

    int pc_idx;
    int wrap_ref;

    initial begin
        // reset
        step();
        check("reset_W", {29'b0, W}, 32'd0);
        check("reset_RUN", {31'b0, RUN}, 32'd0);
        check("reset_CNT", {28'b0, CYC_CNT}, 32'd0);
        step();
        CLR = 1'b1;
        step();

        // free run, 2-beat cycles, QD held for 10 edges
        QD = 1'b1;
        repeat (10) step();
        check("free_W_at10", {29'b0, W}, 32'b010);
        check("free_CNT_at10", {28'b0, CYC_CNT}, 32'd4);
        QD = 1'b0; STOP = 1'b1;
        step();
        STOP = 1'b0;
        step();
        check("free_RUN_end", {31'b0, RUN}, 32'd0);
        check("free_CNT_end", {28'b0, CYC_CNT}, 32'd5);

        // single step, 3-beat cycles, QD held past the end of each cycle
        STEP = 1'b1; LONG = 1'b1;
        for (int p = 0; p < 3; p++) begin
            QD = 1'b1;
            step(); check("step_B1", {29'b0, W}, 32'b001);
            step(); check("step_B2", {29'b0, W}, 32'b010);
            step(); check("step_B3", {29'b0, W}, 32'b100);
            step(); check("step_end", {29'b0, W}, 32'b000);
            step(); check("step_hold_idle", {31'b0, RUN}, 32'd0);
            QD = 1'b0;
            step();
        end
        check("step_CNT", {28'b0, CYC_CNT}, 32'd8);

        // STOP during W1 of the second cycle: cycle still runs to W3
        STEP = 1'b0; LONG = 1'b1;
        QD = 1'b1; step();
        QD = 1'b0; step(); step(); step();
        check("stop_cyc2_B1", {29'b0, W}, 32'b001);
        STOP = 1'b1; step();
        STOP = 1'b0;
        check("stop_B2", {29'b0, W}, 32'b010);
        step(); check("stop_B3", {29'b0, W}, 32'b100);
        step(); check("stop_idle", {31'b0, RUN}, 32'd0);
        check("stop_CNT", {28'b0, CYC_CNT}, 32'd10);

        // breakpoint at PC 5, PC advancing once per cycle with LIR in W1
        LONG = 1'b0; BRK_EN = 1'b1; BRK_ADDR = 8'h05; pc_idx = 0;
        QD = 1'b1;
        for (int i = 0; i < 60 && !(i > 0 && !RUN); i++) begin
            step();
            QD = 1'b0;
            if (W == 3'b001) begin
                LIR = 1'b1; PC = ADDR_W'(pc_idx); pc_idx++;
            end else begin
                LIR = 1'b0;
            end
        end
        LIR = 1'b0;
        check("brk_halted", {31'b0, RUN}, 32'd0);
        check("brk_hit", {31'b0, BRK_HIT}, 32'd1);
        check("brk_pc_count", pc_idx, 32'd6);
        check("brk_CNT", {28'b0, CYC_CNT}, 32'd0);
        QD = 1'b1; step();
        check("brk_clear", {31'b0, BRK_HIT}, 32'd0);
        check("brk_resume_W", {29'b0, W}, 32'b001);
        QD = 1'b0; STEP = 1'b1; BRK_EN = 1'b0;
        step(); step();
        check("brk_resume_CNT", {28'b0, CYC_CNT}, 32'd1);
        STEP = 1'b0;

        // counter wrap with 1-beat cycles
        SHORT = 1'b1; wrap_ref = m_cnt;
        QD = 1'b1; step();
        QD = 1'b0;
        repeat (16) step();
        check("wrap_CNT", {28'b0, CYC_CNT}, wrap_ref);
        check("wrap_RUN", {31'b0, RUN}, 32'd1);
        STOP = 1'b1; step();
        STOP = 1'b0; SHORT = 1'b0;
        check("wrap_CNT_stop", {28'b0, CYC_CNT}, 32'd2);

        // asynchronous reset in the middle of B2 of a long cycle
        LONG = 1'b1;
        QD = 1'b1; step();
        QD = 1'b0; step();
        CLR = 1'b0;
        #1;
        check("clr_W", {29'b0, W}, 32'd0);
        check("clr_RUN", {31'b0, RUN}, 32'd0);
        check("clr_CNT", {28'b0, CYC_CNT}, 32'd0);
        step();
        CLR = 1'b1;
        step();

        // randomized stimulus
        BRK_ADDR = 8'h03;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) QD = ~QD;
            STEP   = ($urandom_range(0, 5) == 0);
            SHORT  = $urandom_range(0, 1) == 1;
            LONG   = $urandom_range(0, 1) == 1;
            STOP   = ($urandom_range(0, 15) == 0);
            LIR    = $urandom_range(0, 1) == 1;
            PC     = ADDR_W'($urandom_range(0, 7));
            BRK_EN = ($urandom_range(0, 3) == 0);
            CLR    = ($urandom_range(0, 299) != 0);
            step();
            if (!CLR) begin
                #1;
                check("rand_clr_W", {29'b0, W}, 32'd0);
                CLR = 1'b1;
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_run_sequencer.md
Name: beat_run_sequencer

Overview:
- Generates the W[3:1] beat signals consumed by the hardwired instruction controller.
- Extends each machine cycle according to that controller's SHORT/LONG requests and halts on its STOP.
- Adds run/single-step control from the QD start button, a PC breakpoint, and a completed-cycle counter for the console display.
- Sits between the console switches/buttons and the controller, in the T3 clock domain.

Parameters:
- ADDR_W, 8, width of PC and breakpoint address.
- CNT_W, 16, width of the completed-cycle counter.

Ports:
- T3  input  1  clock; all state updates on the falling edge of T3.
- CLR  input  1  asynchronous, active-low reset (#CLR).
- QD  input  1  start button level; debounced externally; edge-detected here.
- STEP  input  1  1 = single machine cycle per QD press; 0 = free run.
- SHORT  input  1  from controller: current cycle ends after W1.
- LONG  input  1  from controller: current cycle extends to W3.
- STOP  input  1  from controller: halt at end of current cycle.
- LIR  input  1  from controller: instruction fetch in this beat.
- PC  input  ADDR_W  current program counter.
- BRK_EN  input  1  breakpoint enable.
- BRK_ADDR  input  ADDR_W  breakpoint address.
- W  output  3  one-hot beat: W[1], W[2], W[3]; 000 when idle.
- RUN  output  1  1 while beats are being issued.
- BRK_HIT  output  1  sticky breakpoint-hit flag.
- CYC_CNT  output  CNT_W  number of completed machine cycles.

Behaviour:
- Reset (CLR=0, asynchronous, any time including mid-cycle):
  - State IDLE; W=000; RUN=0; BRK_HIT=0; CYC_CNT=0.
  - Internal stop_pend=0; qd_q=0.
- Edge detection: qd_q <= QD every falling edge of T3. A start event is QD=1 and qd_q=0.
- States: IDLE, B1, B2, B3. W is decoded from the state (B1→001, B2→010, B3→100). RUN=1 in B1..B3.
- Transitions, evaluated at each falling edge of T3 using inputs sampled at that edge:
  - IDLE: on a start event → B1. Also clears BRK_HIT and stop_pend. Otherwise stay in IDLE.
  - B1: if SHORT → end-of-cycle; else → B2.
  - B2: if LONG → B3; else → end-of-cycle.
  - B3: → end-of-cycle.
- End-of-cycle:
  - CYC_CNT increments by 1, wrapping 2^CNT_W-1 → 0.
  - Next state is IDLE if any of these hold: stop_pend, STOP, STEP=1, or breakpoint match this cycle.
  - Otherwise next state is B1 (back-to-back cycles, no idle gap).
- stop_pend: set when STOP=1 is sampled in any beat. Cleared on entering IDLE. STOP never truncates a beat; the current cycle always completes.
- Breakpoint match: BRK_EN=1, LIR=1 and PC==BRK_ADDR, sampled in any beat. Sets BRK_HIT=1, which holds until the next start event or reset. The cycle containing the match completes, then the block goes to IDLE.
- Start events while RUN=1 are ignored. Holding QD high produces no repeat starts.
- SHORT and LONG both asserted in B1: SHORT wins.
- STEP changed while running: takes effect at the next end-of-cycle.
- CYC_CNT is cleared only by CLR.
- Only W[1] is asserted in the first beat after a start; there are no glitch beats on entry to or exit from IDLE.

Test Plan:
- CLR pulsed low mid-B2 with LONG=1 → W=000, RUN=0, CYC_CNT=0 immediately, before the next T3 edge.
- STEP=0, SHORT=0, LONG=0, one QD press → W sequence 001,010,001,010…; CYC_CNT increments every 2 T3 cycles; QD held high for 10 cycles gives exactly one start.
- STEP=1, LONG=1, three QD presses → each press yields exactly 001,010,100 then 000; CYC_CNT=3; RUN low between presses.
- Free run, STOP pulsed 1 during W[1] of the cycle after start, LONG=1 in that cycle → W[2] and W[3] still issued, then IDLE; CYC_CNT=2.
- BRK_EN=1, BRK_ADDR=8'h05, PC stepping 0,1,2… with LIR in W1 → halts at end of the cycle with PC=5; BRK_HIT=1; the next QD clears BRK_HIT and resumes at B1.
- CYC_CNT preloaded near wrap (CNT_W=4, 15 cycles run) → after 16 completed cycles CYC_CNT=0; no other side effects.
